// File: rtl/hdmi_i2c_pkg.sv
// hdmi_i2c_pkg: shared constants for the HDMI-path I2C target.
// State encoding, ACK/NACK bit levels and the glitch-filter length.
package hdmi_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int FILT_LEN = 3;

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: 2-FF synchronizer, optional glitch filter, edge detect.
// Ports: CLK, RST (async, high), line_in -> level, rise, fall.
// HDMI_I2C_TARGET_GLITCH_FILTER_EN adds a FILT_LEN-cycle stability filter.
module i2c_line_cond
  import hdmi_i2c_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       lvl_q;

  // Idle bus is high; resetting to 1 avoids a false edge out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], line_in};
  end

`ifdef HDMI_I2C_TARGET_GLITCH_FILTER_EN
  logic       filt;
  logic [1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt <= 1'b1;
      cnt  <= 2'd0;
    end else if (sync[1] == filt) begin
      cnt  <= 2'd0;
    end else if (cnt == 2'(FILT_LEN - 1)) begin
      filt <= sync[1];
      cnt  <= 2'd0;
    end else begin
      cnt  <= cnt + 2'd1;
    end
  end

  assign level = filt;
`else
  assign level = sync[1];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lvl_q <= 1'b1;
    else     lvl_q <= level;
  end

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;

endmodule

// File: rtl/hdmi_i2c_target.sv
// hdmi_i2c_target: I2C target with a 2^REG_AW byte register file.
// Ports: CLK, RST (async, high), I2C_C/I2C_D (open drain, SCL never driven),
//   u_addr -> u_rdata (1 CLK), o_wr_stb/o_wr_addr/o_wr_data, o_busy.
// Build option: HDMI_I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_cond).
module hdmi_i2c_target
  import hdmi_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h38,
  parameter int         REG_AW   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  inout  wire               I2C_C,
  inout  wire               I2C_D,
  input  logic [REG_AW-1:0] u_addr,
  output logic [7:0]        u_rdata,
  output logic              o_wr_stb,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy
);

  localparam int DEPTH = 1 << REG_AW;

  i2c_state_e state, state_n;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_ev, stop_ev, bit_ev, edge_fall;
  logic byte_end, addr_hit, rx_st, ack_st;

  logic [3:0]        bit_cnt;
  logic [7:0]        shreg, rx_byte, rd_byte;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [DEPTH];

  logic sda_oe, sda_oe_n, mack;
  logic rx, ld, sh, cnt_inc, cnt_clr;
  logic wr_en, ptr_ld, smp_ack;

  assign I2C_C = 1'bz;
  assign I2C_D = sda_oe ? 1'b0 : 1'bz;

  i2c_line_cond u_scl (
    .CLK     (CLK),
    .RST     (RST),
    .line_in (I2C_C),
    .level   (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_cond u_sda (
    .CLK     (CLK),
    .RST     (RST),
    .line_in (I2C_D),
    .level   (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_ev  = sda_fall & scl;
  assign stop_ev   = sda_rise & scl;
  assign bit_ev    = scl_rise & ~start_ev & ~stop_ev;
  assign edge_fall = scl_fall & ~start_ev & ~stop_ev;

  assign byte_end = (bit_cnt == 4'd8);
  assign addr_hit = (shreg[7:1] == DEV_ADDR);
  assign rx_byte  = {shreg[6:0], sda};
  assign rd_byte  = regs[ptr];

  assign rx_st  = (state == ST_ADDR) || (state == ST_PTR) ||
                  (state == ST_WDATA);
  assign ack_st = (state == ST_ADDR_ACK) || (state == ST_PTR_ACK) ||
                  (state == ST_WDATA_ACK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_ev) begin
      state_n = ST_ADDR;
    end else if (stop_ev) begin
      state_n = ST_IDLE;
    end else if (edge_fall) begin
      unique case (state)
        ST_ADDR:
          if (byte_end) state_n = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:
          state_n = shreg[0] ? ST_RDATA : ST_PTR;
        ST_PTR:
          if (byte_end) state_n = ST_PTR_ACK;
        ST_PTR_ACK:
          state_n = ST_WDATA;
        ST_WDATA:
          if (byte_end) state_n = ST_WDATA_ACK;
        ST_WDATA_ACK:
          state_n = ST_WDATA;
        ST_RDATA:
          if (byte_end) state_n = ST_RDATA_ACK;
        ST_RDATA_ACK:
          state_n = (mack == I2C_ACK) ? ST_RDATA : ST_IGNORE;
        default: ;
      endcase
    end
  end

  // Datapath controls. SDA only ever changes on a detected SCL fall.
  always_comb begin
    sda_oe_n = sda_oe;
    rx       = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    wr_en    = 1'b0;
    ptr_ld   = 1'b0;
    smp_ack  = 1'b0;
    if (start_ev || stop_ev) begin
      sda_oe_n = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      unique case (1'b1)
        bit_ev && rx_st && !byte_end: begin
          rx      = 1'b1;
          cnt_inc = 1'b1;
          wr_en   = (state == ST_WDATA) && (bit_cnt == 4'd7);
          ptr_ld  = (state == ST_PTR) && (bit_cnt == 4'd7);
        end
        bit_ev && (state == ST_RDATA) && !byte_end:
          cnt_inc = 1'b1;
        bit_ev && (state == ST_RDATA_ACK):
          smp_ack = 1'b1;
        edge_fall && rx_st && byte_end:
          sda_oe_n = (state != ST_ADDR) || addr_hit;
        edge_fall && ack_st: begin
          cnt_clr  = 1'b1;
          ld       = (state == ST_ADDR_ACK) && shreg[0];
          sda_oe_n = (state == ST_ADDR_ACK) && shreg[0] && !rd_byte[7];
        end
        edge_fall && (state == ST_RDATA) && !byte_end: begin
          sh       = 1'b1;
          sda_oe_n = ~shreg[6];
        end
        edge_fall && (state == ST_RDATA) && byte_end:
          sda_oe_n = 1'b0;
        edge_fall && (state == ST_RDATA_ACK): begin
          cnt_clr  = 1'b1;
          ld       = (mack == I2C_ACK);
          sda_oe_n = (mack == I2C_ACK) && !rd_byte[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sda_oe    <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      ptr       <= '0;
      mack      <= I2C_NACK;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= 8'd0;
      o_busy    <= 1'b0;
      u_rdata   <= 8'd0;
    end else begin
      sda_oe   <= sda_oe_n;
      o_wr_stb <= wr_en;
      u_rdata  <= regs[u_addr];

      if (cnt_clr)      bit_cnt <= 4'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;

      if (rx)      shreg <= rx_byte;
      else if (ld) shreg <= rd_byte;
      else if (sh) shreg <= {shreg[6:0], 1'b0};

      if (ptr_ld) begin
        ptr <= rx_byte[REG_AW-1:0];
      end else if (wr_en) begin
        o_wr_addr <= ptr;
        o_wr_data <= rx_byte;
        ptr       <= ptr + REG_AW'(1);
      end else if (ld) begin
        ptr <= ptr + REG_AW'(1);
      end

      if (smp_ack) mack <= sda;

      // A mismatching repeated START also ends the busy window.
      if (stop_ev)
        o_busy <= 1'b0;
      else if (edge_fall && (state == ST_ADDR) && byte_end)
        o_busy <= addr_hit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'd0;
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// tb_hdmi_i2c_target: directed I2C master with a transaction-level model.
// Model tracks register contents, pointer and expected write strobes.
module tb_hdmi_i2c_target;

  localparam int AW = 4;
  localparam int TQ = 100;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl_bus;
  wire  sda_bus;
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (scl_bus);
  pullup (sda_bus);

  logic [AW-1:0] u_addr = '0;
  logic [AW-1:0] u_addr_q = '0;
  logic [7:0]    u_rdata;
  logic          o_wr_stb;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;
  logic          o_busy;

  hdmi_i2c_target dut (
    .CLK       (CLK),
    .RST       (RST),
    .I2C_C     (scl_bus),
    .I2C_D     (sda_bus),
    .u_addr    (u_addr),
    .u_rdata   (u_rdata),
    .o_wr_stb  (o_wr_stb),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_busy    (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  logic [7:0]  exp_regs [16];
  int          m_ptr;
  bit          m_addressed;
  bit          m_first;
  logic [11:0] wr_q [$];
  logic [11:0] q_e;
  bit          busy_low_chk = 1'b0;
  bit          rd_chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    m_ptr = 0;
    m_addressed = 1'b0;
    m_first = 1'b0;
    wr_q.delete();
  endfunction

  // Returns the SDA level the 9th bit must show.
  function automatic logic model_addr(input logic [7:0] b);
    m_addressed = (b[7:1] == 7'h38);
    m_first = 1'b1;
    return m_addressed ? 1'b0 : 1'b1;
  endfunction

  function automatic logic model_wr(input logic [7:0] b);
    if (!m_addressed) return 1'b1;
    if (m_first) begin
      m_ptr = int'(b) % 16;
      m_first = 1'b0;
    end else begin
      exp_regs[m_ptr] = b;
      wr_q.push_back({4'(m_ptr), b});
      m_ptr = (m_ptr + 1) % 16;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_rd();
    logic [7:0] d;
    d = exp_regs[m_ptr];
    m_ptr = (m_ptr + 1) % 16;
    return d;
  endfunction

  always @(posedge CLK) u_addr_q <= u_addr;

  always @(negedge CLK) begin
    if (!RST) begin
      if (o_wr_stb) begin
        stb_cnt++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_stb: unexpected pulse addr %0h data %0h",
                   o_wr_addr, o_wr_data);
        end else begin
          q_e = wr_q.pop_front();
          chk("wr_addr", 32'(o_wr_addr), 32'(q_e[11:8]));
          chk("wr_data", 32'(o_wr_data), 32'(q_e[7:0]));
        end
      end
      if (busy_low_chk) chk("busy_low", 32'(o_busy), 0);
      if (rd_chk_en && (u_addr == u_addr_q))
        chk("u_rdata", 32'(u_rdata), 32'(exp_regs[u_addr]));
    end
  end

  task automatic bit_x(input logic drv, output logic smp);
    m_sda = drv;
    #TQ m_scl = 1'b1;
    #TQ smp = sda_bus;
    #TQ m_scl = 1'b0;
    #TQ;
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    #TQ m_scl = 1'b1;
    #TQ m_sda = 1'b0;
    #TQ m_scl = 1'b0;
    #TQ;
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    #TQ m_scl = 1'b1;
    #TQ m_sda = 1'b1;
    #(4 * TQ);
  endtask

  task automatic send(input logic [7:0] b, input bit is_addr,
                      input string nm);
    logic a, e, dmy;
    e = is_addr ? model_addr(b) : model_wr(b);
    for (int i = 7; i >= 0; i--) bit_x(b[i], dmy);
    bit_x(1'b1, a);
    chk(nm, 32'(a), 32'(e));
  endtask

  task automatic recv(input logic ack, output logic [7:0] d,
                      output logic rel);
    logic [7:0] e;
    e = model_rd();
    for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
    bit_x(ack, rel);
    chk("rd_data", 32'(d), 32'(e));
  endtask

  task automatic peek(input int a, input logic [7:0] want, input string nm);
    @(posedge CLK);
    #2 u_addr = AW'(a);
    repeat (2) @(posedge CLK);
    #1 chk(nm, 32'(u_rdata), 32'(want));
  endtask

  task automatic sweep();
    rd_chk_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      @(posedge CLK);
      #2 u_addr = AW'(a);
      repeat (2) @(posedge CLK);
    end
    @(negedge CLK);
    #1 rd_chk_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_stb"},   32'(o_wr_stb), 0);
    chk({nm, "_waddr"}, 32'(o_wr_addr), 0);
    chk({nm, "_wdata"}, 32'(o_wr_data), 0);
    chk({nm, "_busy"},  32'(o_busy), 0);
    chk({nm, "_rdata"}, 32'(u_rdata), 0);
    chk({nm, "_sda"},   32'(sda_bus), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       rel;
    logic       dmy;
    logic [7:0] pb;
    model_reset();

    repeat (3) @(posedge CLK);
    #1 chk_reset_vals("reset");
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);

    // single write
    do_start();
    send(8'h70, 1'b1, "t1_addr_ack");
    chk("t1_busy_mid", 32'(o_busy), 1);
    send(8'h05, 1'b0, "t1_ptr_ack");
    send(8'hA5, 1'b0, "t1_data_ack");
    do_stop();
    chk("t1_busy_end", 32'(o_busy), 0);
    chk("t1_stb_cnt", 32'(stb_cnt), 1);
    chk("t1_q_empty", 32'(wr_q.size()), 0);
    peek(5, 8'hA5, "t1_reg5");
    sweep();

    // burst with pointer wrap
    do_start();
    send(8'h70, 1'b1, "t2_addr_ack");
    send(8'h0E, 1'b0, "t2_ptr_ack");
    send(8'h11, 1'b0, "t2_d0_ack");
    send(8'h22, 1'b0, "t2_d1_ack");
    send(8'h33, 1'b0, "t2_d2_ack");
    do_stop();
    chk("t2_stb_cnt", 32'(stb_cnt), 4);
    chk("t2_q_empty", 32'(wr_q.size()), 0);
    peek(14, 8'h11, "t2_reg14");
    peek(15, 8'h22, "t2_reg15");
    peek(0, 8'h33, "t2_reg0");
    sweep();

    // read with repeated START
    do_start();
    send(8'h70, 1'b1, "t3_addr_ack");
    send(8'h0E, 1'b0, "t3_ptr_ack");
    do_start();
    send(8'h71, 1'b1, "t3_raddr_ack");
    recv(1'b0, d, rel);
    chk("t3_b0", 32'(d), 32'h11);
    recv(1'b0, d, rel);
    chk("t3_b1", 32'(d), 32'h22);
    recv(1'b1, d, rel);
    chk("t3_b2", 32'(d), 32'h33);
    chk("t3_nack_rel", 32'(rel), 1);
    do_stop();
    chk("t3_busy_end", 32'(o_busy), 0);
    // pointer now 1: a fresh read returns reg[1], still 0
    do_start();
    send(8'h71, 1'b1, "t3p_addr_ack");
    recv(1'b1, d, rel);
    chk("t3_ptr1", 32'(d), 32'h00);
    do_stop();

    // address mismatch
    busy_low_chk = 1'b1;
    do_start();
    send(8'h72, 1'b1, "t4_addr_nack");
    send(8'h05, 1'b0, "t4_b1_nack");
    send(8'hFF, 1'b0, "t4_b2_nack");
    do_stop();
    busy_low_chk = 1'b0;
    chk("t4_stb_cnt", 32'(stb_cnt), 4);
    peek(5, 8'hA5, "t4_reg5");
    sweep();

    // STOP after 4 bits of a data byte
    do_start();
    send(8'h70, 1'b1, "t5_addr_ack");
    send(8'h02, 1'b0, "t5_ptr_ack");
    pb = 8'hC3;
    for (int i = 7; i >= 4; i--) bit_x(pb[i], dmy);
    chk("t5_busy_mid", 32'(o_busy), 1);
    do_stop();
    chk("t5_busy_end", 32'(o_busy), 0);
    chk("t5_sda_rel", 32'(sda_bus), 1);
    chk("t5_stb_cnt", 32'(stb_cnt), 4);
    sweep();

    // reset while driving a 0 data bit
    do_start();
    send(8'h70, 1'b1, "t6_addr_ack");
    send(8'h0E, 1'b0, "t6_ptr_ack");
    do_start();
    send(8'h71, 1'b1, "t6_raddr_ack");
    d = model_rd();
    chk("t6_bit7_drive", 32'(sda_bus), 32'(d[7]));
    @(posedge CLK);
    #1 RST = 1'b1;
    #2 chk_reset_vals("t6_rst");
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    repeat (5) @(posedge CLK);
    do_start();
    send(8'h70, 1'b1, "t6w_addr_ack");
    send(8'h03, 1'b0, "t6w_ptr_ack");
    send(8'h5A, 1'b0, "t6w_data_ack");
    do_stop();
    chk("t6_stb_cnt", 32'(stb_cnt), 5);
    peek(3, 8'h5A, "t6_reg3");
    peek(14, 8'h00, "t6_reg14_cleared");
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
